// File: rtl/gcd_core_if.sv
// Operand/result bus for the subtractive GCD engine.
// Optional iter_cnt member exists only with GCD_ITER_COUNT_EN.
interface gcd_core_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH-1:0] iter_cnt;

  modport master (
    output start, data_in,
    input  result, done, busy, iter_cnt
  );

  modport slave (
    input  start, data_in,
    output result, done, busy, iter_cnt
  );
`else
  modport master (
    output start, data_in,
    input  result, done, busy
  );

  modport slave (
    input  start, data_in,
    output result, done, busy
  );
`endif
endinterface

// File: rtl/gcd_core.sv
// Iterative subtractive GCD engine: operand regs, comparator, FSM.
// GCD_ITER_COUNT_EN adds a saturating subtraction counter (iter_cnt).
module gcd_core #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  gcd_core_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CALC,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;

  logic a_zero;
  logic b_zero;
  logic eq;
  logic gt;
  logic lt;
  logic fin;

  assign a_zero = (a_q == '0);
  assign b_zero = (b_q == '0);
  assign eq     = (a_q == b_q);
  assign gt     = (a_q > b_q);
  assign lt     = (a_q < b_q);
  assign fin    = a_zero | b_zero | eq;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; start only matters in IDLE and DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = LOAD_A;
      LOAD_A:  state_d = LOAD_B;
      LOAD_B:  state_d = CALC;
      CALC:    if (fin) state_d = DONE;
      DONE:    if (bus.start) state_d = LOAD_A;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, one subtract per CALC cycle, result on exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        LOAD_A: a_q <= bus.data_in;
        LOAD_B: b_q <= bus.data_in;
        CALC: begin
          if (a_zero) begin
            result_q <= b_q;
          end else if (b_zero) begin
            result_q <= a_q;
          end else if (eq) begin
            result_q <= a_q;
          end else if (gt) begin
            a_q <= a_q - b_q;
          end else if (lt) begin
            b_q <= b_q - a_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH-1:0] iter_q;

  // Count subtracting CALC cycles, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_q <= '0;
    end else if (state_q == LOAD_A) begin
      iter_q <= '0;
    end else if (state_q == CALC && !fin && iter_q != '1) begin
      iter_q <= iter_q + 1'b1;
    end
  end

  assign bus.iter_cnt = iter_q;
`endif

  assign bus.result = result_q;
  assign bus.done   = (state_q == DONE);
  assign bus.busy   = (state_q == LOAD_A) |
                      (state_q == LOAD_B) |
                      (state_q == CALC);

endmodule

// File: tb/tb_gcd_core.sv
// Directed vector bench for gcd_core.
// Build with GCD_ITER_COUNT_EN to also check iter_cnt.
module tb_gcd_core;

  localparam int W      = 16;
  localparam int BUDGET = 70000;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    int           calc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  gcd_core_if #(.WIDTH(W)) bus ();

  gcd_core #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Leaves the bench at the negedge inside the first CALC cycle
  task automatic load(input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      input bit hold);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start   = hold;
    bus.data_in = a;
    @(negedge clk);
    bus.data_in = b;
    @(negedge clk);
  endtask

  // Counts CALC cycles from the current negedge until done
  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < BUDGET) begin
      n++;
      @(negedge clk);
    end
    check("done_reached", {31'd0, bus.done}, 32'd1);
  endtask

  vec_t vecs[10];

  initial begin
    int n;
    logic [W-1:0] prev;

    vecs[0] = '{a: 143,   b: 78, res: 13, calc: 7};
    vecs[1] = '{a: 48,    b: 18, res: 6,  calc: 5};
    vecs[2] = '{a: 17,    b: 17, res: 17, calc: 1};
    vecs[3] = '{a: 0,     b: 25, res: 25, calc: 1};
    vecs[4] = '{a: 40,    b: 0,  res: 40, calc: 1};
    vecs[5] = '{a: 0,     b: 0,  res: 0,  calc: 1};
    vecs[6] = '{a: 12,    b: 8,  res: 4,  calc: 3};
    vecs[7] = '{a: 7,     b: 3,  res: 1,  calc: 5};
    vecs[8] = '{a: 10,    b: 35, res: 5,  calc: 5};
    vecs[9] = '{a: 65535, b: 1,  res: 1,  calc: 65535};

    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.data_in = '0;
    repeat (2) @(negedge clk);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
`ifdef GCD_ITER_COUNT_EN
    check("rst_iter", 32'(bus.iter_cnt), 32'd0);
`endif
    rst_n = 1'b1;

    prev = '0;
    for (int i = 0; i < 10; i++) begin
      load(vecs[i].a, vecs[i].b, 1'b0);
      check($sformatf("v%0d_busy", i), {31'd0, bus.busy}, 32'd1);
      check($sformatf("v%0d_hold", i), 32'(bus.result), 32'(prev));
      wait_done(n);
      check($sformatf("v%0d_result", i), 32'(bus.result),
            32'(vecs[i].res));
      check($sformatf("v%0d_cycles", i), n, vecs[i].calc);
      check($sformatf("v%0d_idle", i), {31'd0, bus.busy}, 32'd0);
`ifdef GCD_ITER_COUNT_EN
      check($sformatf("v%0d_iter", i), 32'(bus.iter_cnt),
            32'(vecs[i].calc - 1));
`endif
      prev = vecs[i].res;
    end

    // start pulsed during CALC is ignored
    load(48, 18, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n);
    check("calc_start_cycles", n, 4);
    check("calc_start_result", 32'(bus.result), 32'd6);
    repeat (2) @(negedge clk);
    check("done_stays", {31'd0, bus.done}, 32'd1);

    // start held high: new load from DONE, done is a one-cycle pulse
    load(12, 8, 1'b1);
    check("held_result_old", 32'(bus.result), 32'd6);
    wait_done(n);
    check("held_cycles", n, 3);
    check("held_result", 32'(bus.result), 32'd4);
    @(negedge clk);
    check("pulse_done", {31'd0, bus.done}, 32'd0);
    check("pulse_busy", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wait_done(n);
    check("reload_result", 32'(bus.result), 32'd8);

    // asynchronous reset in the middle of CALC
    load(65535, 1, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_result", 32'(bus.result), 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load(143, 78, 1'b0);
    wait_done(n);
    check("post_rst_result", 32'(bus.result), 32'd13);
    check("post_rst_cycles", n, 7);
`ifdef GCD_ITER_COUNT_EN
    check("post_rst_iter", 32'(bus.iter_cnt), 32'd6);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
